// File: rtl/fetch_queue.sv
// Instruction fetch queue feeding the decode stage: sequential word fetch, circular buffer
// of {instr, pc}, stall/redirect handling. Optional macro FETCH_QUEUE_BYPASS_EN forwards a
// response straight to decode when the queue is empty.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic [6:0]  OpD,
    output logic [2:0]  funct3D,
    output logic        funct7b5D
);

    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
    localparam logic [CW:0]   DepthW  = (CW + 1)'(DEPTH);
    localparam logic [31:0]   Nop     = 32'h0000_0013;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, inflight_d;

    logic has_data, push, bypass, pop, pop_buf, wr_en;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        has_data    = (count_q != '0);
        // Same-cycle pop is deliberately not credited toward free space.
        imem_req_o  = reset_n && !redirect_i &&
                      (({1'b0, count_q} + (CW + 1)'(inflight_q)) < DepthW);
        imem_addr_o = fetch_pc_q;
        push        = inflight_q && !redirect_i;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass      = push && !has_data;
`else
        bypass      = 1'b0;
`endif
        dec_valid_o = has_data || bypass;
        pop         = dec_valid_o && dec_ready_i && !redirect_i;
        pop_buf     = pop && has_data;
        wr_en       = push && !(bypass && pop);

        InstrD   = Nop;
        PCD      = '0;
        PCPlus4D = '0;
        if (has_data) begin
            InstrD   = instr_mem[head_q];
            PCD      = pc_mem[head_q];
            PCPlus4D = pc_mem[head_q] + 32'd4;
        end else if (bypass) begin
            InstrD   = imem_rdata_i;
            PCD      = req_pc_q;
            PCPlus4D = req_pc_q + 32'd4;
        end
    end

    assign OpD       = InstrD[6:0];
    assign funct3D   = InstrD[14:12];
    assign funct7b5D = InstrD[30];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = imem_req_o;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (imem_req_o) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop_buf) head_d = next_ptr(head_q);
            if (wr_en)   tail_d = next_ptr(tail_q);
            case ({wr_en, pop_buf})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            instr_mem[tail_q] <= imem_rdata_i;
            pc_mem[tail_q]    <= req_pc_q;
        end
    end

    // Credit-based request gating makes this unreachable.
    a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
        !(wr_en && !pop_buf && count_q == DepthC));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand sequences for
// stall/redirect/reset, and random traffic against a queue-based reference model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int LAT = 1;
    localparam bit BYP = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] instr_d, pc_d, pc4_d;
    logic [6:0]  op_d;
    logic [2:0]  f3_d;
    logic        f7b5_d;

    logic        redirect2 = 1'b0;
    logic        ready2 = 1'b1;
    logic        req2, valid2;
    logic [31:0] addr2, rdata2 = '0, instr2, pc2, pc4_2;
    logic [6:0]  op2;
    logic [2:0]  f3_2;
    logic        f7b5_2;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .reset_n(reset_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
        .dec_valid_o(dec_valid), .dec_ready_i(dec_ready), .InstrD(instr_d), .PCD(pc_d),
        .PCPlus4D(pc4_d), .OpD(op_d), .funct3D(f3_d), .funct7b5D(f7b5_d)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .redirect_i(redirect2), .redirect_pc_i(32'h0),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_rdata_i(rdata2),
        .dec_valid_o(valid2), .dec_ready_i(ready2), .InstrD(instr2), .PCD(pc2),
        .PCPlus4D(pc4_2), .OpD(op2), .funct3D(f3_2), .funct7b5D(f7b5_2)
    );

    bit ident = 1'b1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ident ? a : ((a * 32'h9E37_79B1) ^ 32'h3C5A_9613);
    endfunction

    // Memory: data valid exactly one cycle after the request.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        rdata2     <= req2 ? addr2 : 32'hDEAD_BEEF;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of PCs waiting for decode plus one outstanding fetch.
    logic [31:0] mq[$];
    logic [31:0] m_fetch_pc, m_inf_pc;
    bit          m_inf;
    bit          cur_rd, cur_rdy, e_req, e_valid, e_byp;
    logic [31:0] cur_rpc, e_pc, e_instr;

    task automatic model_reset(input logic [31:0] rpc);
        mq.delete();
        m_fetch_pc = rpc;
        m_inf_pc   = rpc;
        m_inf      = 1'b0;
    endtask

    task automatic drive_check(input bit rd, input logic [31:0] rpc, input bit rdy);
        redirect    = rd;
        redirect_pc = rpc;
        dec_ready   = rdy;
        cur_rd = rd; cur_rpc = rpc; cur_rdy = rdy;
        #1;
        e_req   = !rd && ((mq.size() + int'(m_inf)) < DEPTH);
        e_byp   = BYP && m_inf && !rd && (mq.size() == 0);
        e_valid = (mq.size() != 0) || e_byp;
        e_pc    = (mq.size() != 0) ? mq[0] : m_inf_pc;
        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, m_fetch_pc);
        chk("dec_valid", dec_valid, e_valid);
        if (e_valid) begin
            e_instr = mem_word(e_pc);
            chk("InstrD", instr_d, e_instr);
            chk("PCD", pc_d, e_pc);
            chk("PCPlus4D", pc4_d, e_pc + 32'd4);
            chk("OpD", op_d, e_instr[6:0]);
            chk("funct3D", f3_d, e_instr[14:12]);
            chk("funct7b5D", f7b5_d, e_instr[30]);
        end else begin
            chk("InstrD_nop", instr_d, NOP);
            chk("PCD_zero", pc_d, 32'h0);
            chk("PCPlus4D_zero", pc4_d, 32'h0);
        end
    endtask

    task automatic advance();
        bit popped, had;
        if (cur_rd) begin
            mq.delete();
            m_inf      = 1'b0;
            m_fetch_pc = cur_rpc;
        end else begin
            popped = e_valid && cur_rdy;
            had    = (mq.size() != 0);
            if (m_inf && !(e_byp && popped)) mq.push_back(m_inf_pc);
            if (popped && had) void'(mq.pop_front());
            m_inf = e_req;
            if (e_req) begin
                m_inf_pc   = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic cycle(input bit rd, input logic [31:0] rpc, input bit rdy);
        drive_check(rd, rpc, rdy);
        advance();
    endtask

    // Called at a negedge; returns at the negedge where reset is released (cycle 0).
    task automatic do_reset();
        #2 reset_n = 1'b0;
        redirect  = 1'b0;
        dec_ready = 1'b1;
        #1;
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_InstrD", instr_d, NOP);
        chk("rst_PCD", pc_d, 32'h0);
        chk("rst_imem_req", imem_req, 1'b0);
        model_reset(32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit          rdy;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[7];

    initial begin
        for (int k = 0; k < 7; k++) begin
            tbl[k].rdy       = 1'b1;
            tbl[k].exp_req   = 1'b1;
            tbl[k].exp_addr  = 32'(4 * k);
            tbl[k].exp_valid = (k >= LAT);
            tbl[k].exp_pc    = (k >= LAT) ? 32'(4 * (k - LAT)) : 32'h0;
        end

        @(negedge clk);
        do_reset();

        // Reset release, ready=1, instr = addr.
        for (int k = 0; k < 7; k++) begin
            drive_check(1'b0, 32'h0, tbl[k].rdy);
            chk("tbl_req", imem_req, tbl[k].exp_req);
            chk("tbl_addr", imem_addr, tbl[k].exp_addr);
            chk("tbl_valid", dec_valid, tbl[k].exp_valid);
            if (tbl[k].exp_valid) begin
                chk("tbl_pcd", pc_d, tbl[k].exp_pc);
                chk("tbl_op", op_d, tbl[k].exp_pc[6:0]);
            end
            if (k >= LAT && k - LAT < 3) begin
                chk("wrap_valid", valid2, 1'b1);
                chk("wrap_pcd", pc2, RPC2 + 32'(4 * (k - LAT)));
                if (k - LAT == 1) chk("wrap_plus4", pc4_2, 32'h0);
            end
            advance();
        end

        // Decode stall: queue fills, requests stop, then drains without gaps.
        for (int k = 0; k < 10; k++) cycle(1'b0, 32'h0, 1'b0);
        drive_check(1'b0, 32'h0, 1'b1);
        chk("stall_req_low", imem_req, 1'b0);
        chk("stall_full_valid", dec_valid, 1'b1);
        advance();
        for (int k = 0; k < 8; k++) begin
            drive_check(1'b0, 32'h0, 1'b1);
            chk("drain_no_gap", dec_valid, 1'b1);
            advance();
        end

        // Redirect with a fetch in flight.
        drive_check(1'b1, 32'h100, 1'b1);
        chk("redir_no_req", imem_req, 1'b0);
        advance();
        drive_check(1'b0, 32'h0, 1'b1);
        chk("redir_flushed", dec_valid, 1'b0);
        chk("redir_addr", imem_addr, 32'h100);
        advance();
        drive_check(1'b0, 32'h0, 1'b1);
        chk("redir_t2_valid", dec_valid, BYP);
        if (BYP) chk("redir_t2_pcd", pc_d, 32'h100);
        advance();
        drive_check(1'b0, 32'h0, 1'b1);
        chk("redir_t3_valid", dec_valid, 1'b1);
        chk("redir_t3_pcd", pc_d, BYP ? 32'h104 : 32'h100);
        advance();

        // Full queue, redirect and ready together: flush wins, no pop.
        for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 1'b0);
        drive_check(1'b1, 32'h2000, 1'b1);
        chk("fullredir_no_req", imem_req, 1'b0);
        advance();
        drive_check(1'b0, 32'h0, 1'b1);
        chk("fullredir_empty", dec_valid, 1'b0);
        advance();
        for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 1'b1);

        // Reset mid-stream with a full queue; switch memory contents while held.
        for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 1'b0);
        ident = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_check(1'b0, 32'h0, 1'b1);
            chk("postrst_valid", dec_valid, k >= LAT);
            advance();
        end

        // Random traffic against the model.
        for (int k = 0; k < 500; k++) begin
            cycle($urandom_range(0, 19) == 0,
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC),
                  $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
